// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter and its baud generator.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Counter width for a modulus, never below one bit.
  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read-side bundle: exposed word, fill-level code and pop strobe.
interface uart_tx_if #(
  parameter int n = 8
);
  logic [n-1:0] data;
  logic [2:0]   status;
  logic         clk_o;

  // The transmitter consumes words; the FIFO supplies them.
  modport master (input data, input status, output clk_o);
  modport slave  (output data, output status, input clk_o);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: one-cycle tick every div enabled cycles, held at zero when idle.
module uart_tx_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int div = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = cnt_w(div);
  localparam logic [CW-1:0] LAST = CW'(div - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && !clr_i && (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (clr_i || !en_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and frames them on tx.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int n    = 8,
  parameter int div  = 104,
  parameter int stop = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_tx_if.master   fifo,
  output logic        tx,
  output logic        busy
);

  localparam int BW = $clog2(n) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(n - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(stop - 1);

  uart_state_e   state_q, state_d;
  logic [n-1:0]  sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          pop_q;
  logic          busy_q;
  logic          tick;
  logic          baud_clr;
  logic          baud_en;
  logic          unused_status;

  assign unused_status = ^fifo.status[2:1];

  uart_tx_baud_gen #(
    .div (div)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (baud_clr),
    .en_i   (baud_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    baud_clr = 1'b0;
    baud_en  = 1'b0;
    unique case (state_q)
      IDLE:  if (fifo.status[0]) state_d = POP;
      POP:   state_d = LATCH;
      LATCH: begin
        sh_d     = fifo.data;
        bit_d    = '0;
        baud_clr = 1'b1;
        state_d  = START;
      end
      START: begin
        baud_en = 1'b1;
        if (tick) state_d = DATA;
      end
      DATA: begin
        baud_en = 1'b1;
        if (tick) begin
          sh_d = sh_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        baud_en = 1'b1;
        // The last stop cycle is the only mid-stream point where fill level is looked at.
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = fifo.status[0] ? POP : IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = sh_d[0];
  end

  // Outputs are registered from the next state so the pop strobe is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      pop_q   <= (state_d == POP);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign fifo.clk_o = pop_q;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: FIFO models, frame decoder and expected-word scoreboard.
module tb_uart_tx;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx1, busy1, tx2, busy2;

  uart_tx_if #(.n(8)) f1 ();
  uart_tx_if #(.n(8)) f2 ();

  uart_tx #(.n(8), .div(DIV), .stop(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo(f1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.n(8), .div(DIV), .stop(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo(f2), .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // FIFO models: the word at the read pointer appears on data at each pop strobe.
  logic [7:0] mem1 [64];
  logic [7:0] mem2 [64];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;

  assign f1.status = {2'b00, (wr1 != rd1)};
  assign f2.status = {2'b00, (wr2 != rd2)};

  always @(posedge f1.clk_o) begin
    f1.data <= mem1[rd1 % 64];
    rd1     <= rd1 + 1;
  end

  always @(posedge f2.clk_o) begin
    f2.data <= mem2[rd2 % 64];
    rd2     <= rd2 + 1;
  end

  int hi1 = 0;
  always @(negedge clk) if (f1.clk_o === 1'b1) hi1 <= hi1 + 1;

  // Frame decoder for dut1; frames cut short by reset are discarded.
  logic [7:0] rx_word [64];
  logic       rx_ok   [64];
  int         rx_cnt = 0;
  logic [7:0] m_w;
  logic       m_ok, m_ab;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx1 === 1'b0) begin
        m_w = '0; m_ok = 1'b1; m_ab = 1'b0;
        for (int i = 1; i < DIV && !m_ab; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) m_ab = 1'b1;
          if (tx1 !== 1'b0) m_ok = 1'b0;
        end
        for (int b = 0; b < 8 && !m_ab; b++) begin
          for (int i = 0; i < DIV && !m_ab; i++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) m_ab = 1'b1;
            if (i == 0) m_w[b] = tx1;
            else if (tx1 !== m_w[b]) m_ok = 1'b0;
          end
        end
        for (int i = 0; i < DIV && !m_ab; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) m_ab = 1'b1;
          if (tx1 !== 1'b1) m_ok = 1'b0;
        end
        if (!m_ab) begin
          rx_word[rx_cnt % 64] = m_w;
          rx_ok[rx_cnt % 64]   = m_ok;
          rx_cnt = rx_cnt + 1;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int rx_rd = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input logic [7:0] w, input bit expect_it);
    mem1[wr1 % 64] = w;
    wr1 = wr1 + 1;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic push2(input logic [7:0] w);
    mem2[wr2 % 64] = w;
    wr2 = wr2 + 1;
  endtask

  task automatic wait_start(input bit sel);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if ((sel ? tx2 : tx1) === 1'b0) break;
    end
    chk(sel ? "start_seen2" : "start_seen1", 128'(sel ? tx2 : tx1), 128'(1'b0));
  endtask

  task automatic expect_frames(input int k);
    int target;
    logic [7:0] w;
    target = rx_rd + k;
    for (int i = 0; i < 3000 && rx_cnt < target; i++) @(posedge clk);
    #1;
    chk("frame_count", 128'(rx_cnt), 128'(target));
    while (rx_rd < rx_cnt && rx_rd < target) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 128'(exp_q.size()), 128'(1));
        break;
      end
      w = exp_q.pop_front();
      chk("sb_word", 128'(rx_word[rx_rd % 64]), 128'(w));
      chk("sb_framing", 128'(rx_ok[rx_rd % 64]), 128'(1'b1));
      rx_rd++;
    end
  endtask

  // Line level at cycle c of a frame carrying w (start, 8 data LSB first, stop ones).
  function automatic logic frame_bit(input logic [7:0] w, input int c);
    int b;
    b = c / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    return 1'b1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad, nb, base, gap;
    logic [127:0] wave, expw;

    rst_n = 1'b0;
    push1(8'hA5, 1'b1);

    // Reset held with a non-empty FIFO.
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (tx1 !== 1'b1 || f1.clk_o !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    chk("reset_hold", 128'(bad), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame A5 with exact cycle timing.
    step(1);
    chk("pop_after_reset", 128'(f1.clk_o), 128'(1'b1));
    chk("busy_rise", 128'(busy1), 128'(1'b1));
    step(1);
    chk("latch_strobe_low", 128'(f1.clk_o), 128'(1'b0));
    chk("latch_tx_high", 128'(tx1), 128'(1'b1));
    step(1);
    chk("start_edge", 128'(tx1), 128'(1'b0));
    wave = '0;
    wave[0] = tx1;
    nb = 3;
    for (int i = 1; i < 40; i++) begin
      step(1);
      wave[i] = tx1;
      if (busy1 === 1'b1) nb++;
    end
    expw = '0;
    for (int c = 0; c < 40; c++) expw[c] = frame_bit(8'hA5, c);
    chk("a5_waveform", wave, expw);
    chk("busy_cycles", 128'(nb), 128'(42));
    step(1);
    chk("busy_fall", 128'(busy1), 128'(1'b0));
    chk("single_pops", 128'(rd1), 128'(1));
    chk("strobe_width", 128'(hi1), 128'(1));
    expect_frames(1);

    // Empty FIFO stays idle.
    bad = 0;
    repeat (1000) begin
      step(1);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || f1.clk_o !== 1'b0) bad++;
    end
    chk("empty_idle", 128'(bad), 128'(0));
    chk("empty_no_pop", 128'(rd1), 128'(1));

    // Back-to-back 00 then FF with two stop bits.
    push2(8'h00);
    push2(8'hFF);
    wait_start(1'b1);
    wave = '0;
    wave[0] = tx2;
    for (int i = 1; i < 92; i++) begin
      step(1);
      wave[i] = tx2;
    end
    expw = '0;
    for (int c = 0; c < 92; c++) begin
      if (c < 44)      expw[c] = frame_bit(8'h00, c);
      else if (c < 46) expw[c] = 1'b1;
      else if (c < 90) expw[c] = frame_bit(8'hFF, c - 46);
      else             expw[c] = 1'b1;
    end
    gap = -1;
    for (int c = 36; c < 92; c++) begin
      if (wave[c] == 1'b0) begin
        gap = c - 44;
        break;
      end
    end
    chk("b2b_gap", 128'(gap), 128'(2));
    chk("b2b_waveform", wave, expw);
    chk("b2b_pops", 128'(rd2), 128'(2));
    chk("b2b_idle", 128'(busy2), 128'(1'b0));

    // FIFO fills while frame 1 is on the line.
    base = rd1;
    push1(8'h11, 1'b1);
    wait_start(1'b0);
    step(5);
    push1(8'h22, 1'b1);
    step(10);
    push1(8'h33, 1'b1);
    step(10);
    push1(8'h44, 1'b1);
    step(13);
    chk("no_midframe_pop", 128'(rd1 - base), 128'(1));
    expect_frames(4);
    chk("fill_pops", 128'(rd1 - base), 128'(4));

    // Reset during data bit 3 of an all-zero word; the next word must follow intact.
    base = rd1;
    push1(8'h00, 1'b0);
    push1(8'h5A, 1'b1);
    wait_start(1'b0);
    step(17);
    chk("pre_reset_low", 128'(tx1), 128'(1'b0));
    rst_n = 1'b0;
    step(1);
    chk("abort_tx_high", 128'(tx1), 128'(1'b1));
    chk("abort_busy_low", 128'(busy1), 128'(1'b0));
    chk("abort_strobe_low", 128'(f1.clk_o), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_frames(1);
    chk("abort_pops", 128'(rd1 - base), 128'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
